// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: link FSM states, frame geometry and common keyboard
// command bytes, used by both the host transmitter and the receiver.
package ps2_pkg;

  localparam int PS2_DATA_BITS   = 8;
  localparam int PS2_FRAME_FALLS = 11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_REL
  } ps2_state_e;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the raw PS/2 clock and data pins, plus a
// falling-edge strobe on the synchronised clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_pin,
  input  logic i_data_pin,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_fall
);

  logic [1:0] r_clk_ff;
  logic [1:0] r_data_ff;
  logic       r_clk_prev;

  // Reset to the idle (released, pulled-up) line level so no false edge appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_ff   <= 2'b11;
      r_data_ff  <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_ff   <= {r_clk_ff[0], i_clk_pin};
      r_data_ff  <= {r_data_ff[0], i_data_pin};
      r_clk_prev <= r_clk_ff[1];
    end
  end

  assign o_clk_sync  = r_clk_ff[1];
  assign o_data_sync = r_data_ff[1];
  assign o_fall      = r_clk_prev & ~r_clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// then shifts one command byte out on the device-generated clock.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_clk_in,
  input  logic       PS2_data_in,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output ps2_state_e dbg_state
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [19:0]      TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

  logic w_clk_sync, w_data_sync, w_fall;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_clk_pin  (PS2_clk_in),
    .i_data_pin (PS2_data_in),
    .o_clk_sync (w_clk_sync),
    .o_data_sync(w_data_sync),
    .o_fall     (w_fall)
  );

  ps2_state_e       r_state, w_state_nx;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nx;
  logic [19:0]      r_to_cnt, w_to_cnt_nx;
  logic [3:0]       r_bit_cnt, w_bit_cnt_nx;
  logic [7:0]       r_byte, w_byte_nx;
  logic             r_parity, w_parity_nx;
  logic             r_nack, w_nack_nx;
  logic             r_clk_oe, w_clk_oe_nx;
  logic             r_data_oe, w_data_oe_nx;
  logic             r_done, w_done_nx;
  logic             r_error, w_error_nx;
  logic             r_ready, w_ready_nx;
  logic             r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bit_cnt <= '0;
      r_byte    <= '0;
      r_parity  <= 1'b0;
      r_nack    <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_inh_cnt <= w_inh_cnt_nx;
      r_to_cnt  <= w_to_cnt_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_byte    <= w_byte_nx;
      r_parity  <= w_parity_nx;
      r_nack    <= w_nack_nx;
      r_clk_oe  <= w_clk_oe_nx;
      r_data_oe <= w_data_oe_nx;
      r_done    <= w_done_nx;
      r_error   <= w_error_nx;
      r_ready   <= w_ready_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
    end
  end

  // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and is held low during the tx_done cycle,
  // so a request seen alongside tx_done is taken one cycle later.
  always_comb begin
    w_state_nx   = r_state;
    w_inh_cnt_nx = r_inh_cnt;
    w_to_cnt_nx  = r_to_cnt;
    w_bit_cnt_nx = r_bit_cnt;
    w_byte_nx    = r_byte;
    w_parity_nx  = r_parity;
    w_nack_nx    = r_nack;
    w_clk_oe_nx  = r_clk_oe;
    w_data_oe_nx = r_data_oe;
    w_done_nx    = 1'b0;
    w_error_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clk_oe_nx  = 1'b0;
        w_data_oe_nx = 1'b0;
        if (tx_valid && r_ready) begin
          w_byte_nx    = tx_data;
          w_parity_nx  = ps2_odd_parity(tx_data);
          w_nack_nx    = 1'b0;
          w_inh_cnt_nx = '0;
          w_bit_cnt_nx = '0;
          w_clk_oe_nx  = 1'b1;
          w_state_nx   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        w_inh_cnt_nx = r_inh_cnt + 1'b1;
        if (r_inh_cnt == INH_LAST) begin
          w_clk_oe_nx = 1'b0;
          w_to_cnt_nx = '0;
          w_state_nx  = ST_REQ;
        end else if (r_inh_cnt == INH_PRE) begin
          w_data_oe_nx = 1'b1;
        end
      end
      ST_REQ, ST_DATA, ST_PARITY, ST_STOP, ST_ACK: begin
        w_to_cnt_nx = r_to_cnt + 1'b1;
        // The timeout terminal count takes priority over a coincident fall.
        if (r_to_cnt == TO_LAST) begin
          w_clk_oe_nx  = 1'b0;
          w_data_oe_nx = 1'b0;
          w_done_nx    = 1'b1;
          w_error_nx   = 1'b1;
          w_state_nx   = ST_IDLE;
        end else if (w_fall) begin
          w_bit_cnt_nx = r_bit_cnt + 1'b1;
          case (r_state)
            ST_REQ: begin
              w_data_oe_nx = ~r_byte[0];
              w_state_nx   = ST_DATA;
            end
            ST_DATA: begin
              w_data_oe_nx = ~r_byte[r_bit_cnt[2:0]];
              if (r_bit_cnt == 4'(PS2_DATA_BITS - 1)) w_state_nx = ST_PARITY;
            end
            ST_PARITY: begin
              w_data_oe_nx = ~r_parity;
              w_state_nx   = ST_STOP;
            end
            ST_STOP: begin
              w_data_oe_nx = 1'b0;
              w_state_nx   = ST_ACK;
            end
            default: begin
              w_nack_nx  = w_data_sync;
              w_state_nx = ST_WAIT_REL;
            end
          endcase
        end
      end
      ST_WAIT_REL: begin
        if (w_clk_sync && w_data_sync) begin
          w_done_nx  = 1'b1;
          w_error_nx = r_nack;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_ready_nx = (w_state_nx == ST_IDLE) && !w_done_nx;
  end

  assign PS2_clk_oe  = r_clk_oe;
  assign PS2_data_oe = r_data_oe;
  assign tx_ready    = r_ready;
  assign busy        = r_busy;
  assign tx_done     = r_done;
  assign tx_error    = r_error;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks frames
// out of the host and the sampled bits are compared with frames built from the byte.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 300;
  localparam int TMO  = 2000;
  localparam int LOW  = 12;
  localparam int HIGH = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       PS2_clk_oe, PS2_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, tx_done, tx_error;
  ps2_state_e dbg_state;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_pin, ps2_data_pin;
  assign ps2_clk_pin  = ~(PS2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(PS2_data_oe | dev_data_low);

  int n_checks = 0;
  int n_pass = 0;
  bit scramble = 1'b0;
  logic [9:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .PS2_clk_in (ps2_clk_pin),
    .PS2_data_in(ps2_data_pin),
    .PS2_clk_oe (PS2_clk_oe),
    .PS2_data_oe(PS2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .dbg_state  (dbg_state)
  );

  // monitors: length of each clock-inhibit pulse, start-bit onset, done/error pulses
  int hi_run = 0, data_first = 0, last_hi_len = 0, last_data_first = 0;
  int done_cnt = 0, err_cnt = 0, err_alone = 0;
  always @(negedge clk) begin
    if (PS2_clk_oe) begin
      hi_run <= hi_run + 1;
      if (PS2_data_oe && data_first == 0) data_first <= hi_run + 1;
    end else if (hi_run > 0) begin
      last_hi_len     <= hi_run;
      last_data_first <= data_first;
      hi_run          <= 0;
      data_first      <= 0;
    end
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_error && !tx_done) err_alone <= err_alone + 1;
  end

  // reference frame: eight data bits LSB first, odd parity, stop bit
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i];
    f[8] = ($countones(b) % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
    if (scramble && busy) tx_data = 8'($urandom);
  endtask

  task automatic send_req(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic dev_frame(input bit ack, input int nfalls, output logic [9:0] got, output bit ok);
    got = '0;
    ok  = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      tick();
      if (!PS2_clk_oe && PS2_data_oe) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    repeat (4) tick();
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk_low = 1'b1;
      repeat (LOW) tick();
      if (k <= 10) got[k-1] = ps2_data_pin;
      if (k == nfalls && nfalls < 11) return;
      dev_clk_low = 1'b0;
      if (k == 10) dev_data_low = ack;
      if (k == 11) dev_data_low = 1'b0;
      if (k < nfalls) repeat (HIGH) tick();
    end
  endtask

  task automatic wait_done(output bit seen, output bit err);
    seen = 1'b0;
    err  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_done) begin seen = 1'b1; err = tx_error; break; end
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if ({PS2_clk_oe, PS2_data_oe} !== 2'b00) $display("FAIL reset_oe: got %b expected 00", {PS2_clk_oe, PS2_data_oe}); else n_pass++;
    n_checks++; if ({busy, tx_ready} !== 2'b01) $display("FAIL reset_busy_ready: got %b expected 01", {busy, tx_ready}); else n_pass++;
    n_checks++; if ({tx_done, tx_error} !== 2'b00) $display("FAIL reset_done_err: got %b expected 00", {tx_done, tx_error}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_send_ed();
    logic [9:0] got, exp;
    bit ok, seen, err;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_req(PS2_CMD_SET_LED, ok);
    n_checks++; if (!ok) $display("FAIL ed_ready: got 0 expected 1"); else n_pass++;
    n_checks++; if ({PS2_clk_oe, busy, tx_ready} !== 3'b110) $display("FAIL ed_accept: got %b expected 110", {PS2_clk_oe, busy, tx_ready}); else n_pass++;
    exp_q.push_back(frame_of(PS2_CMD_SET_LED));
    dev_frame(1'b1, 11, got, ok);
    n_checks++; if (!ok) $display("FAIL ed_req: got no request expected request"); else n_pass++;
    n_checks++; if (last_hi_len != INH) $display("FAIL ed_inhibit_len: got %0d expected %0d", last_hi_len, INH); else n_pass++;
    n_checks++; if (last_data_first != INH) $display("FAIL ed_start_bit: got %0d expected %0d", last_data_first, INH); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL ed_frame: got %b expected %b", got, exp); else n_pass++;
    wait_done(seen, err);
    n_checks++; if ({seen, err} !== 2'b10) $display("FAIL ed_done: got %b expected 10", {seen, err}); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL ed_idle: got %b expected 1", tx_ready); else n_pass++;
    n_checks++; if ((done_cnt - d0) != 1 || err_cnt != e0) $display("FAIL ed_pulses: got %0d/%0d expected 1/0", done_cnt - d0, err_cnt - e0); else n_pass++;
  endtask

  task automatic test_parity_sweep();
    logic [7:0] bytes [7];
    logic [9:0] got, exp;
    bit ok, seen, err;
    bytes[0] = 8'h00; bytes[1] = 8'h01; bytes[2] = 8'hFF; bytes[3] = 8'hF4;
    for (int i = 4; i < 7; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 7; i++) begin
      send_req(bytes[i], ok);
      exp_q.push_back(frame_of(bytes[i]));
      dev_frame(1'b1, 11, got, ok);
      exp = exp_q.pop_front();
      n_checks++; if (got[8] !== exp[8]) $display("FAIL parity_%02h: got %b expected %b", bytes[i], got[8], exp[8]); else n_pass++;
      n_checks++; if (got !== exp) $display("FAIL frame_%02h: got %b expected %b", bytes[i], got, exp); else n_pass++;
      wait_done(seen, err);
      n_checks++; if ({seen, err} !== 2'b10) $display("FAIL done_%02h: got %b expected 10", bytes[i], {seen, err}); else n_pass++;
    end
  endtask

  task automatic test_nack();
    logic [7:0] b;
    logic [9:0] got, exp;
    bit ok, seen, err;
    b = 8'($urandom);
    send_req(b, ok);
    exp_q.push_back(frame_of(b));
    dev_frame(1'b0, 11, got, ok);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL nack_frame: got %b expected %b", got, exp); else n_pass++;
    wait_done(seen, err);
    n_checks++; if ({seen, err} !== 2'b11) $display("FAIL nack_done_err: got %b expected 11", {seen, err}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({busy, tx_ready} !== 2'b01) $display("FAIL nack_idle: got %b expected 01", {busy, tx_ready}); else n_pass++;
    n_checks++; if (err_alone != 0) $display("FAIL err_without_done: got %0d expected 0", err_alone); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok, found;
    int n;
    send_req(8'($urandom), ok);
    found = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      @(negedge clk);
      if (!PS2_clk_oe && PS2_data_oe) begin found = 1'b1; break; end
    end
    n = 1;
    for (int i = 0; i < TMO + 50; i++) begin
      if (tx_done) break;
      @(negedge clk);
      n++;
    end
    n_checks++; if (!found || n != TMO + 1) $display("FAIL timeout_len: got %0d expected %0d", n, TMO + 1); else n_pass++;
    n_checks++; if ({PS2_clk_oe, PS2_data_oe, tx_done, tx_error} !== 4'b0011) $display("FAIL timeout_out: got %b expected 0011", {PS2_clk_oe, PS2_data_oe, tx_done, tx_error}); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL timeout_ready: got %b expected 1", tx_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [9:0] got, exp;
    bit ok, seen, err;
    b = 8'($urandom) & 8'hEF;
    send_req(b, ok);
    dev_frame(1'b1, 5, got, ok);
    n_checks++; if ({PS2_clk_oe, PS2_data_oe} !== 2'b01) $display("FAIL mid_bit4: got %b expected 01", {PS2_clk_oe, PS2_data_oe}); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if ({PS2_clk_oe, PS2_data_oe, busy} !== 3'b000) $display("FAIL async_reset: got %b expected 000", {PS2_clk_oe, PS2_data_oe, busy}); else n_pass++;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_req(PS2_CMD_ENABLE, ok);
    exp_q.push_back(frame_of(PS2_CMD_ENABLE));
    dev_frame(1'b1, 11, got, ok);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL after_reset_frame: got %b expected %b", got, exp); else n_pass++;
    wait_done(seen, err);
    n_checks++; if ({seen, err} !== 2'b10) $display("FAIL after_reset_done: got %b expected 10", {seen, err}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [9:0] got, exp;
    bit ok, seen, err;
    a = 8'($urandom); b = ~a;
    for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
    tx_data = a; tx_valid = 1'b1;
    @(negedge clk);
    exp_q.push_back(frame_of(a));
    scramble = 1'b1;
    dev_frame(1'b1, 11, got, ok);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL b2b_first: got %b expected %b", got, exp); else n_pass++;
    wait_done(seen, err);
    tx_data = b;
    n_checks++; if ({seen, tx_ready} !== 2'b10) $display("FAIL b2b_done_ready: got %b expected 10", {seen, tx_ready}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({tx_ready, PS2_clk_oe} !== 2'b10) $display("FAIL b2b_idle_cycle: got %b expected 10", {tx_ready, PS2_clk_oe}); else n_pass++;
    @(negedge clk);
    n_checks++; if (PS2_clk_oe !== 1'b1) $display("FAIL b2b_second_accept: got %b expected 1", PS2_clk_oe); else n_pass++;
    exp_q.push_back(frame_of(b));
    dev_frame(1'b1, 11, got, ok);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL b2b_second: got %b expected %b", got, exp); else n_pass++;
    wait_done(seen, err);
    tx_valid = 1'b0;
    scramble = 1'b0;
    n_checks++; if ({seen, err} !== 2'b10) $display("FAIL b2b_second_done: got %b expected 10", {seen, err}); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if ({PS2_clk_oe, tx_ready} !== 2'b01) $display("FAIL b2b_stays_idle: got %b expected 01", {PS2_clk_oe, tx_ready}); else n_pass++;
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_send_ed();
    test_parity_sweep();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
